stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
//
// PURPOSE
//   Downstream consumer of the clock divider's 1 Hz output. Samples the divided
//   square wave in the system clock domain and turns each rising edge into a
//   one-second tick. Runs a start/pause/clear stopwatch and presents MM:SS as
//   four BCD digits to the display stage.
//
// PARAMETERS
//   SAT_MODE   0   0 = wrap 59:59 -> 00:00 and keep running; 1 = hold 59:59 and pause
//   SYNC_DEPTH 2   synchroniser flops on tick_in, start_stop_in, clear_in (>=2)
//
// PORTS
//   clock          in   1  system clock (50 MHz board clock)
//   reset_n        in   1  asynchronous active-low reset
//   tick_in        in   1  divided 1 Hz square wave (50% duty); one rising edge = 1 s
//   start_stop_in  in   1  debounced button level; each rising edge toggles run/pause
//   clear_in       in   1  debounced button level; a rising edge zeroes the count
//   sec_ones       out  4  BCD seconds units, 0-9
//   sec_tens       out  4  BCD seconds tens, 0-5
//   min_ones       out  4  BCD minutes units, 0-9
//   min_tens       out  4  BCD minutes tens, 0-5
//   running        out  1  1 while in RUN
//   max_pulse      out  1  one-cycle pulse on the tick that reaches the 59:59 boundary
//
// BEHAVIOUR
//   - Reset (reset_n=0, async assert): all digits 0, state IDLE, running=0,
//     max_pulse=0, all synchroniser and edge flops 0. Deassertion is synchronous to clock.
//   - Inputs: each passes through SYNC_DEPTH flops, then an edge register.
//     Pulse = sync_out & ~edge_reg, one cycle wide. tick_in held high produces
//     exactly one tick. A reset mid-high input produces one pulse after release.
//   - Latency (SYNC_DEPTH=2): a tick_in rise sampled at edge N updates digits at edge N+2.
//     A start_stop rise sampled at edge N updates running at edge N+2.
//   - States: IDLE (count 00:00, stopped), RUN, PAUSE.
//     IDLE --start--> RUN; RUN --start--> PAUSE; PAUSE --start--> RUN;
//     any --clear--> IDLE, with digits zeroed in the same cycle.
//   - Counting: only in RUN, on a tick pulse. sec_ones 9->0 carries to sec_tens.
//     sec_tens 5->0 carries to min_ones. min_ones 9->0 carries to min_tens.
//     Digits never leave their legal BCD ranges.
//   - 59:59 boundary, tick in RUN:
//     SAT_MODE=0: count becomes 00:00, max_pulse=1 for one cycle, state stays RUN.
//     SAT_MODE=1: count holds 59:59, max_pulse=1 for one cycle, state -> PAUSE.
//     A further start from this held 59:59 enters RUN. The next tick holds 59:59,
//     pulses max_pulse again, and returns to PAUSE.
//   - Same-cycle events, in priority order:
//     clear > tick/start. clear with a tick yields 00:00 in IDLE, and max_pulse=0.
//     In RUN, a tick and start in the same cycle: the tick is counted, then state -> PAUSE.
//     In PAUSE or IDLE, a tick and start in the same cycle: the tick is dropped, then state -> RUN.
//   - Ticks in IDLE or PAUSE are discarded, not queued.
//   - Outputs are registered; no combinational path from inputs to outputs.
//
// TESTING
//   1. Assert reset_n=0 mid-count at 12:34 -> all digits 0 and running=0 immediately
//      (async). After release, state is IDLE.
//   2. start pulse, then 10 tick_in rises -> 00:10. Each digit update lands exactly
//      2 clock edges after the tick rise is sampled.
//   3. Preload via 3599 ticks with SAT_MODE=0 -> 59:59. Next tick -> 00:00,
//      max_pulse high 1 cycle, running=1.
//   4. Repeat step 3 with SAT_MODE=1 -> holds 59:59, max_pulse 1 cycle, running=0.
//      Extra ticks do not change the count.
//   5. RUN at 00:05, start and tick in the same cycle -> 00:06 and PAUSE.
//      3 more ticks leave it at 00:06. Then clear and tick together -> 00:00, IDLE.
//   6. Hold tick_in high for 100 cycles -> exactly one increment.
//      Toggle start_stop 4 times -> RUN, PAUSE, RUN, PAUSE.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Bundle of the stopwatch's button/tick inputs and BCD display outputs.
// The stimulus side uses the master modport and the stopwatch uses the slave modport.
interface stopwatch_counter_if;
    logic       tick_in;
    logic       start_stop_in;
    logic       clear_in;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       max_pulse;

    modport master (
        output tick_in, start_stop_in, clear_in,
        input  sec_ones, sec_tens, min_ones, min_tens, running, max_pulse
    );

    modport slave (
        input  tick_in, start_stop_in, clear_in,
        output sec_ones, sec_tens, min_ones, min_tens, running, max_pulse
    );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch driven by a 1 Hz square wave. Inputs are synchronised and
// edge-detected; a start/pause/clear FSM gates counting of four BCD digits.
module stopwatch_counter #(
    parameter int SAT_MODE   = 0,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    stopwatch_counter_if.slave  sw
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Bit order in all vectors below: {clear, start_stop, tick}
    logic [2:0]                  in_s;
    logic [SYNC_DEPTH-1:0][2:0]  sync_r;
    logic [2:0]                  sync_out_s;
    logic [2:0]                  edge_r;
    logic [2:0]                  pulse_s;
    logic                        tick_p_s;
    logic                        start_p_s;
    logic                        clear_p_s;

    state_t     state_r, state_nx_s;
    logic [3:0] sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
    logic [3:0] sec_ones_nx_s, sec_tens_nx_s, min_ones_nx_s, min_tens_nx_s;
    logic       running_r, max_pulse_r, max_pulse_nx_s;
    logic       at_max_s;

    assign in_s       = {sw.clear_in, sw.start_stop_in, sw.tick_in};
    assign sync_out_s = sync_r[SYNC_DEPTH-1];
    assign pulse_s    = sync_out_s & ~edge_r;
    assign tick_p_s   = pulse_s[0];
    assign start_p_s  = pulse_s[1];
    assign clear_p_s  = pulse_s[2];

    assign at_max_s = (min_tens_r == 4'd5) && (min_ones_r == 4'd9) &&
                      (sec_tens_r == 4'd5) && (sec_ones_r == 4'd9);

    // Synchroniser chain and edge register for the three inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= '0;
            edge_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], in_s};
            edge_r <= sync_out_s;
        end
    end

    // Next-state, BCD increment and boundary handling; clear overrides everything
    always_comb begin
        state_nx_s     = state_r;
        sec_ones_nx_s  = sec_ones_r;
        sec_tens_nx_s  = sec_tens_r;
        min_ones_nx_s  = min_ones_r;
        min_tens_nx_s  = min_tens_r;
        max_pulse_nx_s = 1'b0;
        if (clear_p_s) begin
            state_nx_s    = ST_IDLE;
            sec_ones_nx_s = 4'd0;
            sec_tens_nx_s = 4'd0;
            min_ones_nx_s = 4'd0;
            min_tens_nx_s = 4'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (tick_p_s && at_max_s) begin
                        max_pulse_nx_s = 1'b1;
                        if (SAT_MODE != 0) begin
                            state_nx_s = ST_PAUSE;
                        end else begin
                            sec_ones_nx_s = 4'd0;
                            sec_tens_nx_s = 4'd0;
                            min_ones_nx_s = 4'd0;
                            min_tens_nx_s = 4'd0;
                        end
                    end else if (tick_p_s) begin
                        // Ripple carry; at_max excluded above keeps min_tens <= 5
                        if (sec_ones_r != 4'd9) begin
                            sec_ones_nx_s = sec_ones_r + 4'd1;
                        end else begin
                            sec_ones_nx_s = 4'd0;
                            if (sec_tens_r != 4'd5) begin
                                sec_tens_nx_s = sec_tens_r + 4'd1;
                            end else begin
                                sec_tens_nx_s = 4'd0;
                                if (min_ones_r != 4'd9) begin
                                    min_ones_nx_s = min_ones_r + 4'd1;
                                end else begin
                                    min_ones_nx_s = 4'd0;
                                    min_tens_nx_s = min_tens_r + 4'd1;
                                end
                            end
                        end
                    end else begin
                        max_pulse_nx_s = 1'b0;
                    end
                    if (start_p_s) begin
                        state_nx_s = ST_PAUSE;
                    end else begin
                        max_pulse_nx_s = max_pulse_nx_s;
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    // Ticks outside RUN are dropped, even alongside a start
                    if (start_p_s) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
                default: begin
                    state_nx_s    = ST_IDLE;
                    sec_ones_nx_s = 4'd0;
                    sec_tens_nx_s = 4'd0;
                    min_ones_nx_s = 4'd0;
                    min_tens_nx_s = 4'd0;
                end
            endcase
        end
    end

    // State, digit and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            sec_ones_r  <= 4'd0;
            sec_tens_r  <= 4'd0;
            min_ones_r  <= 4'd0;
            min_tens_r  <= 4'd0;
            running_r   <= 1'b0;
            max_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            sec_ones_r  <= sec_ones_nx_s;
            sec_tens_r  <= sec_tens_nx_s;
            min_ones_r  <= min_ones_nx_s;
            min_tens_r  <= min_tens_nx_s;
            running_r   <= (state_nx_s == ST_RUN);
            max_pulse_r <= max_pulse_nx_s;
        end
    end

    assign sw.sec_ones  = sec_ones_r;
    assign sw.sec_tens  = sec_tens_r;
    assign sw.min_ones  = min_ones_r;
    assign sw.min_tens  = min_tens_r;
    assign sw.running   = running_r;
    assign sw.max_pulse = max_pulse_r;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: a wrapping and a saturating stopwatch receive identical
// stimulus and are compared against hand-computed MM:SS / running / max_pulse values.
module tb_stopwatch_counter;
    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    stopwatch_counter_if sw_wrap ();
    stopwatch_counter_if sw_sat ();

    stopwatch_counter #(.SAT_MODE(0), .SYNC_DEPTH(2)) u_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .sw      (sw_wrap)
    );

    stopwatch_counter #(.SAT_MODE(1), .SYNC_DEPTH(2)) u_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .sw      (sw_sat)
    );

    logic [15:0] mmss_wrap;
    logic [15:0] mmss_sat;
    assign mmss_wrap = {sw_wrap.min_tens, sw_wrap.min_ones, sw_wrap.sec_tens, sw_wrap.sec_ones};
    assign mmss_sat  = {sw_sat.min_tens, sw_sat.min_ones, sw_sat.sec_tens, sw_sat.sec_ones};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_both(input string tag,
                            input logic [15:0] wrap_mmss, input logic wrap_run,
                            input logic [15:0] sat_mmss,  input logic sat_run);
        chk({tag, "_wrap_mmss"}, {16'd0, mmss_wrap}, {16'd0, wrap_mmss});
        chk({tag, "_wrap_run"},  {31'd0, sw_wrap.running}, {31'd0, wrap_run});
        chk({tag, "_sat_mmss"},  {16'd0, mmss_sat}, {16'd0, sat_mmss});
        chk({tag, "_sat_run"},   {31'd0, sw_sat.running}, {31'd0, sat_run});
    endtask

    task automatic chk_max(input string tag, input logic wrap_max, input logic sat_max);
        chk({tag, "_wrap_max"}, {31'd0, sw_wrap.max_pulse}, {31'd0, wrap_max});
        chk({tag, "_sat_max"},  {31'd0, sw_sat.max_pulse},  {31'd0, sat_max});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic t, input logic s, input logic c);
        sw_wrap.tick_in       = t;
        sw_wrap.start_stop_in = s;
        sw_wrap.clear_in      = c;
        sw_sat.tick_in        = t;
        sw_sat.start_stop_in  = s;
        sw_sat.clear_in       = c;
    endtask

    // High for two edges, low for two: the result is visible on return
    task automatic pulse(input logic t, input logic s, input logic c);
        drive(t, s, c);
        step(2);
        drive(1'b0, 1'b0, 1'b0);
        step(2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        step(3);
        chk_both("reset", 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk_max("reset", 1'b0, 1'b0);
        reset_n = 1'b1;
        step(2);

        // Start, then first tick with exact latency
        pulse(1'b0, 1'b1, 1'b0);
        chk_both("start", 16'h0000, 1'b1, 16'h0000, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        step(2);
        chk_both("lat_n1", 16'h0000, 1'b1, 16'h0000, 1'b1);
        step(1);
        chk_both("lat_n2", 16'h0001, 1'b1, 16'h0001, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        step(1);
        ticks(9);
        chk_both("ten", 16'h0010, 1'b1, 16'h0010, 1'b1);

        // Reach 12:34 and reset asynchronously
        ticks(744);
        chk_both("t1234", 16'h1234, 1'b1, 16'h1234, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_both("async_rst", 16'h0000, 1'b0, 16'h0000, 1'b0);
        step(2);
        reset_n = 1'b1;
        step(2);
        chk_both("post_rst", 16'h0000, 1'b0, 16'h0000, 1'b0);
        ticks(1);
        chk_both("idle_tick", 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Preload to 59:59 then cross the boundary
        pulse(1'b0, 1'b1, 1'b0);
        ticks(3599);
        chk_both("t5959", 16'h5959, 1'b1, 16'h5959, 1'b1);
        chk_max("pre_max", 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        step(2);
        drive(1'b0, 1'b0, 1'b0);
        step(1);
        chk_both("boundary", 16'h0000, 1'b1, 16'h5959, 1'b0);
        chk_max("boundary", 1'b1, 1'b1);
        step(1);
        chk_max("boundary_end", 1'b0, 1'b0);
        ticks(1);
        chk_both("after_bnd", 16'h0001, 1'b1, 16'h5959, 1'b0);
        chk_max("after_bnd", 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_both("restart", 16'h0001, 1'b0, 16'h5959, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        step(2);
        drive(1'b0, 1'b0, 1'b0);
        step(1);
        chk_both("rehold", 16'h0001, 1'b0, 16'h5959, 1'b0);
        chk_max("rehold", 1'b0, 1'b1);
        step(1);
        pulse(1'b0, 1'b0, 1'b1);
        chk_both("clear", 16'h0000, 1'b0, 16'h0000, 1'b0);

        // Same-cycle tick/start/clear priorities
        pulse(1'b0, 1'b1, 1'b0);
        ticks(5);
        chk_both("t0005", 16'h0005, 1'b1, 16'h0005, 1'b1);
        pulse(1'b1, 1'b1, 1'b0);
        chk_both("run_tick_start", 16'h0006, 1'b0, 16'h0006, 1'b0);
        ticks(3);
        chk_both("pause_ticks", 16'h0006, 1'b0, 16'h0006, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        chk_both("pause_tick_start", 16'h0006, 1'b1, 16'h0006, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        step(2);
        drive(1'b0, 1'b0, 1'b0);
        step(1);
        chk_both("clear_tick", 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk_max("clear_tick", 1'b0, 1'b0);
        step(1);
        pulse(1'b1, 1'b1, 1'b0);
        chk_both("idle_tick_start", 16'h0000, 1'b1, 16'h0000, 1'b1);

        // Long-held tick counts once; start toggles
        drive(1'b1, 1'b0, 1'b0);
        step(100);
        drive(1'b0, 1'b0, 1'b0);
        step(2);
        chk_both("held_tick", 16'h0001, 1'b1, 16'h0001, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk_both("toggle1", 16'h0000, 1'b1, 16'h0000, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk_both("toggle2", 16'h0000, 1'b0, 16'h0000, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        chk_both("toggle3", 16'h0000, 1'b1, 16'h0000, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk_both("toggle4", 16'h0000, 1'b0, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
